// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle MIPS-style control unit:
// FSM states, opcode/funct values, ALU function codes and the decoded control bundle.
package mc_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_HALT,
      S_TRAP
   } state_e;

   // Instruction classes steer the FSM; the datapath only sees the control bits.
   typedef enum logic [3:0] {
      C_R_ALU,
      C_I_ALU,
      C_LW,
      C_SW,
      C_BRANCH,
      C_JUMP,
      C_JAL,
      C_JR,
      C_SYSCALL,
      C_ILLEGAL
   } cls_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;

   localparam logic [5:0] ALU_NONE = 6'h00;
   localparam logic [5:0] ALU_ADD  = 6'h20;
   localparam logic [5:0] ALU_ADDU = 6'h21;
   localparam logic [5:0] ALU_AND  = 6'h24;
   localparam logic [5:0] ALU_OR   = 6'h25;
   localparam logic [5:0] ALU_SLT  = 6'h2A;

   typedef struct packed {
      cls_e       cls;
      logic [5:0] alu_ctrl;
      logic       alu_src;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       link;
   } ctrl_t;

endpackage

// File: rtl/mc_decode.sv
// Combinational opcode/funct decoder producing the instruction class and
// datapath control bits consumed by multicycle_ctrl.
module mc_decode
   import mc_pkg::*;
(
   input  logic [5:0] opcode_in,
   input  logic [5:0] funct_in,
   output ctrl_t      ctrl_out
);

   always_comb begin
      // NOTE: every field gets a default before the case so no path leaves a
      // signal unassigned, which would otherwise infer a latch.
      ctrl_out.cls        = C_ILLEGAL;
      ctrl_out.alu_ctrl   = ALU_NONE;
      ctrl_out.alu_src    = 1'b1;
      ctrl_out.reg_dst    = 1'b0;
      ctrl_out.mem_to_reg = 1'b0;
      ctrl_out.link       = 1'b0;

      case (opcode_in)
         OP_RTYPE: begin
            ctrl_out.alu_src  = 1'b0;
            ctrl_out.reg_dst  = 1'b1;
            ctrl_out.alu_ctrl = funct_in;
            if (funct_in == FN_SYSCALL)
               ctrl_out.cls = C_SYSCALL;
            else if (funct_in == FN_JR)
               ctrl_out.cls = C_JR;
            else
               ctrl_out.cls = C_R_ALU;
         end
         OP_BEQ, OP_BNE: begin
            ctrl_out.cls      = C_BRANCH;
            ctrl_out.alu_src  = 1'b0;
            ctrl_out.alu_ctrl = opcode_in;
         end
         OP_J:   ctrl_out.cls = C_JUMP;
         OP_JAL: begin
            ctrl_out.cls  = C_JAL;
            ctrl_out.link = 1'b1;
         end
         OP_ADDI: begin
            ctrl_out.cls      = C_I_ALU;
            ctrl_out.alu_ctrl = ALU_ADD;
         end
         OP_ADDIU: begin
            ctrl_out.cls      = C_I_ALU;
            ctrl_out.alu_ctrl = ALU_ADDU;
         end
         OP_SLTI: begin
            ctrl_out.cls      = C_I_ALU;
            ctrl_out.alu_ctrl = ALU_SLT;
         end
         OP_ANDI: begin
            ctrl_out.cls      = C_I_ALU;
            ctrl_out.alu_ctrl = ALU_AND;
         end
         OP_ORI: begin
            ctrl_out.cls      = C_I_ALU;
            ctrl_out.alu_ctrl = ALU_OR;
         end
         OP_LUI: ctrl_out.cls = C_I_ALU;
         OP_LW: begin
            ctrl_out.cls        = C_LW;
            ctrl_out.alu_ctrl   = ALU_ADDU;
            ctrl_out.mem_to_reg = 1'b1;
         end
         OP_SW: begin
            ctrl_out.cls      = C_SW;
            ctrl_out.alu_ctrl = ALU_ADDU;
         end
         default: ctrl_out.cls = C_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: fetch/decode/exec/mem/wb sequencing, PC update and
// retired-instruction counting. Define ILLEGAL_TRAP_EN to trap undefined opcodes.
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned       ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(32'h0040_0000),
   parameter int unsigned       CNT_W    = 32,
   parameter logic [ADDR_W-1:0] TRAP_VEC = ADDR_W'(32'h0040_0180)
)
(
   input  logic              clock,
   input  logic              reset,
   input  logic [31:0]       instr_in,
   input  logic              imem_ready_in,
   input  logic              dmem_ready_in,
   input  logic              branch_in,
   input  logic [ADDR_W-1:0] rs_data_in,
   output logic [ADDR_W-1:0] pc_out,
   output logic [31:0]       ir_out,
   output logic              imem_rd_out,
   output logic              dmem_rd_out,
   output logic              dmem_wr_out,
   output logic              reg_write_out,
   output logic              reg_dst_out,
   output logic              alu_src_out,
   output logic              mem_to_reg_out,
   output logic              link_out,
   output logic [5:0]        alu_ctrl_out,
   output logic              halted_out,
   output logic [CNT_W-1:0]  instret_out
`ifdef ILLEGAL_TRAP_EN
   ,
   output logic              trap_out,
   output logic [ADDR_W-1:0] epc_out
`endif
);

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic [31:0]       ir_q, ir_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              retire;
   ctrl_t             ctrl;
   logic [ADDR_W-1:0] br_off;
   logic [ADDR_W-1:0] jmp_tgt;
`ifdef ILLEGAL_TRAP_EN
   logic [ADDR_W-1:0] epc_q, epc_d;
`endif

   mc_decode u_decode (
      .opcode_in (ir_q[31:26]),
      .funct_in  (ir_q[5:0]),
      .ctrl_out  (ctrl)
   );

   assign br_off = {{(ADDR_W-18){ir_q[15]}}, ir_q[15:0], 2'b00};

   // Jump keeps the upper PC bits of the already-incremented PC.
   always_comb begin
      jmp_tgt       = pc_q;
      jmp_tgt[27:0] = {ir_q[25:0], 2'b00};
   end

   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ir_d           = ir_q;
      retire         = 1'b0;
      imem_rd_out    = 1'b0;
      dmem_rd_out    = 1'b0;
      dmem_wr_out    = 1'b0;
      reg_write_out  = 1'b0;
      reg_dst_out    = 1'b0;
      alu_src_out    = 1'b0;
      mem_to_reg_out = 1'b0;
      link_out       = 1'b0;
      alu_ctrl_out   = ALU_NONE;
      halted_out     = 1'b0;
`ifdef ILLEGAL_TRAP_EN
      epc_d          = epc_q;
      trap_out       = 1'b0;
`endif

      if (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) begin
         alu_ctrl_out = ctrl.alu_ctrl;
         alu_src_out  = ctrl.alu_src;
      end

      case (state_q)
         S_FETCH: begin
            // Reset parks the FSM in FETCH; the request waits for release.
            imem_rd_out = !reset;
            if (imem_ready_in) begin
               ir_d    = instr_in;
               pc_d    = pc_q + ADDR_W'(4);
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
            if (ctrl.cls == C_SYSCALL)
               state_d = S_HALT;
`ifdef ILLEGAL_TRAP_EN
            if (ctrl.cls == C_ILLEGAL) begin
               state_d = S_TRAP;
               epc_d   = pc_q - ADDR_W'(4);
            end
`else
            // Undefined opcodes continue to EXEC and retire as NOPs.
`endif
         end
         S_EXEC: begin
            case (ctrl.cls)
               C_LW, C_SW:         state_d = S_MEM;
               C_R_ALU, C_I_ALU:   state_d = S_WB;
               C_JAL: begin
                  pc_d    = jmp_tgt;
                  state_d = S_WB;
               end
               C_BRANCH: begin
                  if (branch_in)
                     pc_d = pc_q + br_off;
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               C_JUMP: begin
                  pc_d    = jmp_tgt;
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               C_JR: begin
                  pc_d    = rs_data_in;
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
               default: begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            endcase
         end
         S_MEM: begin
            dmem_rd_out = (ctrl.cls == C_LW);
            dmem_wr_out = (ctrl.cls == C_SW);
            if (dmem_ready_in) begin
               if (ctrl.cls == C_LW) begin
                  state_d = S_WB;
               end else begin
                  state_d = S_FETCH;
                  retire  = 1'b1;
               end
            end
         end
         S_WB: begin
            reg_write_out  = 1'b1;
            reg_dst_out    = ctrl.reg_dst;
            mem_to_reg_out = ctrl.mem_to_reg;
            link_out       = ctrl.link;
            state_d        = S_FETCH;
            retire         = 1'b1;
         end
         S_HALT: halted_out = 1'b1;
`ifdef ILLEGAL_TRAP_EN
         S_TRAP: begin
            trap_out = 1'b1;
            pc_d     = TRAP_VEC;
            state_d  = S_FETCH;
         end
`endif
         default: state_d = S_FETCH;
      endcase
   end

   assign instret_d = retire ? instret_q + CNT_W'(1) : instret_q;

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of statement order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q   <= S_FETCH;
         pc_q      <= RESET_PC;
         ir_q      <= '0;
         instret_q <= '0;
`ifdef ILLEGAL_TRAP_EN
         epc_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         instret_q <= instret_d;
`ifdef ILLEGAL_TRAP_EN
         epc_q     <= epc_d;
`endif
      end
   end

   assign pc_out      = pc_q;
   assign ir_out      = ir_q;
   assign instret_out = instret_q;
`ifdef ILLEGAL_TRAP_EN
   assign epc_out     = epc_q;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl; covers both builds of
// the ILLEGAL_TRAP_EN option.
module tb_multicycle_ctrl;

   localparam logic [31:0] I_ADDIU   = 32'h2422_0005;
   localparam logic [31:0] I_LW      = 32'h8C22_0010;
   localparam logic [31:0] I_SW      = 32'hAC22_0010;
   localparam logic [31:0] I_ADD     = 32'h0022_1820;
   localparam logic [31:0] I_BEQ     = 32'h1022_FFFF;
   localparam logic [31:0] I_BNE     = 32'h1422_0004;
   localparam logic [31:0] I_JR      = 32'h03E0_0008;
   localparam logic [31:0] I_JAL     = 32'h0C10_0080;
   localparam logic [31:0] I_J       = 32'h0810_00C0;
   localparam logic [31:0] I_ILLEGAL = 32'hFC00_0000;
   localparam logic [31:0] I_SYSCALL = 32'h0000_000C;

   logic        clock;
   logic        reset;
   logic [31:0] instr_in;
   logic        imem_ready_in;
   logic        dmem_ready_in;
   logic        branch_in;
   logic [31:0] rs_data_in;
   logic [31:0] pc_out;
   logic [31:0] ir_out;
   logic        imem_rd_out;
   logic        dmem_rd_out;
   logic        dmem_wr_out;
   logic        reg_write_out;
   logic        reg_dst_out;
   logic        alu_src_out;
   logic        mem_to_reg_out;
   logic        link_out;
   logic [5:0]  alu_ctrl_out;
   logic        halted_out;
   logic [31:0] instret_out;
`ifdef ILLEGAL_TRAP_EN
   logic        trap_out;
   logic [31:0] epc_out;
`endif

   int checks = 0;
   int errors = 0;

   multicycle_ctrl dut (
      .clock          (clock),
      .reset          (reset),
      .instr_in       (instr_in),
      .imem_ready_in  (imem_ready_in),
      .dmem_ready_in  (dmem_ready_in),
      .branch_in      (branch_in),
      .rs_data_in     (rs_data_in),
      .pc_out         (pc_out),
      .ir_out         (ir_out),
      .imem_rd_out    (imem_rd_out),
      .dmem_rd_out    (dmem_rd_out),
      .dmem_wr_out    (dmem_wr_out),
      .reg_write_out  (reg_write_out),
      .reg_dst_out    (reg_dst_out),
      .alu_src_out    (alu_src_out),
      .mem_to_reg_out (mem_to_reg_out),
      .link_out       (link_out),
      .alu_ctrl_out   (alu_ctrl_out),
      .halted_out     (halted_out),
      .instret_out    (instret_out)
`ifdef ILLEGAL_TRAP_EN
      ,
      .trap_out       (trap_out),
      .epc_out        (epc_out)
`endif
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Presents one word during FETCH and returns in DECODE.
   task automatic fetch_instr(input logic [31:0] word);
      instr_in      = word;
      imem_ready_in = 1'b1;
      @(negedge clock);
      imem_ready_in = 1'b0;
   endtask

   initial begin
      reset         = 1'b1;
      instr_in      = '0;
      imem_ready_in = 1'b0;
      dmem_ready_in = 1'b0;
      branch_in     = 1'b0;
      rs_data_in    = '0;
      repeat (2) @(negedge clock);
      check("rst_pc", pc_out, 32'h0040_0000);
      check("rst_ir", ir_out, 32'h0);
      check("rst_instret", instret_out, 32'h0);
      check("rst_imem_rd", imem_rd_out, 1'b0);
      check("rst_halted", halted_out, 1'b0);
      check("rst_reg_write", reg_write_out, 1'b0);

      // addiu: 4 cycles, write only in cycle 4
      reset = 1'b0;
      #1;
      check("fetch_req", imem_rd_out, 1'b1);
      instr_in      = I_ADDIU;
      imem_ready_in = 1'b1;
      check("addiu_c1_pc", pc_out, 32'h0040_0000);
      check("addiu_c1_wr", reg_write_out, 1'b0);
      @(negedge clock);
      imem_ready_in = 1'b0;
      check("addiu_c2_pc", pc_out, 32'h0040_0004);
      check("addiu_c2_ir", ir_out, I_ADDIU);
      check("addiu_c2_imem_rd", imem_rd_out, 1'b0);
      check("addiu_c2_wr", reg_write_out, 1'b0);
      @(negedge clock);
      check("addiu_c3_wr", reg_write_out, 1'b0);
      check("addiu_alu", alu_ctrl_out, 6'h21);
      check("addiu_alu_src", alu_src_out, 1'b1);
      @(negedge clock);
      check("addiu_c4_wr", reg_write_out, 1'b1);
      check("addiu_reg_dst", reg_dst_out, 1'b0);
      @(negedge clock);
      check("addiu_c5_wr", reg_write_out, 1'b0);
      check("addiu_instret", instret_out, 32'd1);
      check("addiu_refetch", imem_rd_out, 1'b1);

      // lw with 3 wait cycles: read strobe 4 cycles, WB in cycle 8
      fetch_instr(I_LW);
      @(negedge clock);
      check("lw_exec_rd", dmem_rd_out, 1'b0);
      check("lw_alu", alu_ctrl_out, 6'h21);
      @(negedge clock);
      for (int i = 0; i < 4; i++) begin
         check("lw_mem_rd", dmem_rd_out, 1'b1);
         check("lw_mem_wr", dmem_wr_out, 1'b0);
         dmem_ready_in = (i == 3);
         @(negedge clock);
      end
      dmem_ready_in = 1'b0;
      check("lw_wb_wr", reg_write_out, 1'b1);
      check("lw_wb_m2r", mem_to_reg_out, 1'b1);
      check("lw_wb_rd", dmem_rd_out, 1'b0);
      @(negedge clock);
      check("lw_instret", instret_out, 32'd2);
      check("lw_pc", pc_out, 32'h0040_0008);

      // sw, ready immediately: 4 cycles, no register write
      fetch_instr(I_SW);
      @(negedge clock);
      @(negedge clock);
      check("sw_wr", dmem_wr_out, 1'b1);
      check("sw_rd", dmem_rd_out, 1'b0);
      dmem_ready_in = 1'b1;
      @(negedge clock);
      dmem_ready_in = 1'b0;
      check("sw_done_wr", dmem_wr_out, 1'b0);
      check("sw_no_regwr", reg_write_out, 1'b0);
      check("sw_instret", instret_out, 32'd3);
      check("sw_pc", pc_out, 32'h0040_000C);

      // R-type add
      fetch_instr(I_ADD);
      @(negedge clock);
      check("add_alu", alu_ctrl_out, 6'h20);
      check("add_alu_src", alu_src_out, 1'b0);
      @(negedge clock);
      check("add_wb_wr", reg_write_out, 1'b1);
      check("add_reg_dst", reg_dst_out, 1'b1);
      check("add_m2r", mem_to_reg_out, 1'b0);
      @(negedge clock);
      check("add_instret", instret_out, 32'd4);
      check("add_pc", pc_out, 32'h0040_0010);

      // beq taken, offset -1 word: lands back on itself
      fetch_instr(I_BEQ);
      check("beq_pc_inc", pc_out, 32'h0040_0014);
      branch_in = 1'b1;
      @(negedge clock);
      check("beq_alu", alu_ctrl_out, 6'h04);
      check("beq_alu_src", alu_src_out, 1'b0);
      @(negedge clock);
      branch_in = 1'b0;
      check("beq_pc", pc_out, 32'h0040_0010);
      check("beq_instret", instret_out, 32'd5);
      check("beq_no_regwr", reg_write_out, 1'b0);

      // bne not taken
      fetch_instr(I_BNE);
      @(negedge clock);
      check("bne_alu", alu_ctrl_out, 6'h05);
      @(negedge clock);
      check("bne_pc", pc_out, 32'h0040_0014);
      check("bne_instret", instret_out, 32'd6);

      // jr
      rs_data_in = 32'h0040_0100;
      fetch_instr(I_JR);
      @(negedge clock);
      @(negedge clock);
      check("jr_pc", pc_out, 32'h0040_0100);
      check("jr_instret", instret_out, 32'd7);
      check("jr_fetch", imem_rd_out, 1'b1);

      // jal to 0x0040_0200 with link in WB
      fetch_instr(I_JAL);
      @(negedge clock);
      check("jal_exec_link", link_out, 1'b0);
      @(negedge clock);
      check("jal_link", link_out, 1'b1);
      check("jal_wr", reg_write_out, 1'b1);
      check("jal_pc", pc_out, 32'h0040_0200);
      @(negedge clock);
      check("jal_link_off", link_out, 1'b0);
      check("jal_instret", instret_out, 32'd8);

      // j to 0x0040_0300
      fetch_instr(I_J);
      @(negedge clock);
      @(negedge clock);
      check("j_pc", pc_out, 32'h0040_0300);
      check("j_instret", instret_out, 32'd9);

      // undefined opcode 0x3F
      fetch_instr(I_ILLEGAL);
`ifdef ILLEGAL_TRAP_EN
      @(negedge clock);
      check("trap_pulse", trap_out, 1'b1);
      check("trap_epc", epc_out, 32'h0040_0300);
      @(negedge clock);
      check("trap_pulse_end", trap_out, 1'b0);
      check("trap_pc", pc_out, 32'h0040_0180);
      check("trap_instret", instret_out, 32'd9);
`else
      @(negedge clock);
      @(negedge clock);
      check("nop_pc", pc_out, 32'h0040_0304);
      check("nop_instret", instret_out, 32'd10);
`endif

      // reset during lw memory wait
      fetch_instr(I_LW);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      check("lw_wait_rd", dmem_rd_out, 1'b1);
      #2;
      reset = 1'b1;
      #1;
      check("midrst_pc", pc_out, 32'h0040_0000);
      check("midrst_ir", ir_out, 32'h0);
      check("midrst_instret", instret_out, 32'h0);
      check("midrst_rd", dmem_rd_out, 1'b0);
      check("midrst_imem_rd", imem_rd_out, 1'b0);
      @(negedge clock);
      reset = 1'b0;

      // syscall halts and freezes instret
      fetch_instr(I_ADDIU);
      @(negedge clock);
      @(negedge clock);
      @(negedge clock);
      check("pre_halt_instret", instret_out, 32'd1);
      fetch_instr(I_SYSCALL);
      check("sys_decode_halted", halted_out, 1'b0);
      @(negedge clock);
      check("halted", halted_out, 1'b1);
      imem_ready_in = 1'b1;
      repeat (3) @(negedge clock);
      check("halt_hold", halted_out, 1'b1);
      check("halt_imem_rd", imem_rd_out, 1'b0);
      check("halt_regwr", reg_write_out, 1'b0);
      check("halt_instret", instret_out, 32'd1);
      check("halt_pc", pc_out, 32'h0040_0008);
      reset = 1'b1;
      #1;
      check("halt_rst", halted_out, 1'b0);
      check("halt_rst_pc", pc_out, 32'h0040_0000);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, PC and jump-register width (≥28).
REQ-002 SHALL have parameter RESET_PC, default 32'h0040_0000, PC value after reset.
REQ-003 SHALL have parameter CNT_W, default 32, width of retired-instruction counter.
REQ-004 SHALL have parameter TRAP_VEC, default 32'h0040_0180, PC loaded on illegal-instruction trap.
REQ-005 SHALL have port clock  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-007 SHALL have port instr_in  in  32  instruction word from instruction memory.
REQ-008 SHALL have port imem_ready_in  in  1  instr_in valid this cycle.
REQ-009 SHALL have port dmem_ready_in  in  1  data-memory access completes this cycle.
REQ-010 SHALL have port branch_in  in  1  ALU branch-condition result.
REQ-011 SHALL have port rs_data_in  in  ADDR_W  register rs value (jr target).
REQ-012 SHALL have port pc_out  out  ADDR_W  current PC.
REQ-013 SHALL have port ir_out  out  32  latched instruction register.
REQ-014 SHALL have port imem_rd_out  out  1  instruction fetch request.
REQ-015 SHALL have port dmem_rd_out / dmem_wr_out  out  1 each  data read/write strobes.
REQ-016 SHALL have port reg_write_out, reg_dst_out, alu_src_out, mem_to_reg_out  out  1 each  datapath controls.
REQ-017 SHALL have port link_out  out  1  write PC to r31 (jal).
REQ-018 SHALL have port alu_ctrl_out  out  6  ALU function code.
REQ-019 SHALL have port halted_out  out  1  core halted by syscall.
REQ-020 SHALL have port instret_out  out  CNT_W  retired-instruction count.

Function
REQ-021 SHALL implement states FETCH, DECODE, EXEC, MEM, WB, HALT (plus TRAP, see REQ-036).
REQ-022 FETCH SHALL assert imem_rd_out, hold until imem_ready_in=1, then latch ir<=instr_in, pc<=pc+4 (mod 2^ADDR_W), go DECODE.
REQ-023 DECODE SHALL always go EXEC after one cycle; syscall (op 0, funct 0x0C) SHALL go HALT instead.
REQ-024 EXEC SHALL go MEM for lw(0x23)/sw(0x2B), WB for R-type/addi/addiu/andi/ori/slti/lui/jal, FETCH for beq/bne/j/jr.
REQ-025 MEM SHALL assert dmem_rd_out (lw) or dmem_wr_out (sw) continuously until dmem_ready_in=1; then lw->WB, sw->FETCH.
REQ-026 WB SHALL assert reg_write_out for exactly one cycle, then FETCH; mem_to_reg_out=1 only for lw; link_out=1 only for jal.
REQ-027 Latency: R/I-type 4 cycles, lw 5, sw 4, branch/jump 3, each plus memory wait cycles.
REQ-028 In EXEC, beq/bne with branch_in=1 SHALL set pc<=pc+(sext(imm16)<<2); j/jal SHALL set pc<={pc[ADDR_W-1:28],ir[25:0],2'b00}; jr (funct 0x08) SHALL set pc<=rs_data_in.
REQ-029 alu_ctrl_out SHALL equal funct for R-type; 0x21 for lw/sw/addiu; 0x20 addi; 0x24 andi; 0x25 ori; 0x2A slti; opcode value for beq/bne.
REQ-030 alu_src_out=1 for all non-R-type, non-branch opcodes; reg_dst_out=1 only for R-type.
REQ-031 instret SHALL increment (wrapping) on each transition to FETCH from EXEC, MEM or WB.
REQ-032 HALT SHALL hold all strobes low, halted_out=1, until reset.

Reset
REQ-033 Reset SHALL force FETCH, pc=RESET_PC, ir=0, instret=0, all strobes/controls 0, halted_out=0, asynchronously, including mid-MEM wait.
REQ-034 First fetch SHALL begin the first rising edge after reset deasserts.

Configuration
REQ-035 Macro ILLEGAL_TRAP_EN SHALL compile in trap support; without it undefined opcodes execute as 3-cycle NOPs.
REQ-036 With ILLEGAL_TRAP_EN: undefined opcode in DECODE -> TRAP (1 cycle): outputs trap_out (1, pulse) and epc_out (ADDR_W, <=pc-4) added, pc<=TRAP_VEC, then FETCH; instret not incremented.

Structure
REQ-037 Package mc_pkg SHALL hold the state enum, opcode and funct constants, and ALU code constants.
REQ-038 Sub-module mc_decode SHALL be the combinational opcode/funct -> control/alu_ctrl decoder.

Verification
REQ-039 Reset, imem_ready_in=1, addiu -> pc_out 0x0040_0000->0x0040_0004, reg_write_out high in cycle 4 only, instret_out=1.
REQ-040 lw with dmem_ready_in low 3 cycles -> dmem_rd_out high 4 cycles, WB at cycle 8, mem_to_reg_out=1.
REQ-041 beq, branch_in=1, imm=0xFFFF at pc 0x0040_0010 -> pc_out=0x0040_0010.
REQ-042 jr rs_data_in=0x0040_0100 -> next fetch at 0x0040_0100; jal sets link_out in WB.
REQ-043 syscall -> halted_out=1, instret frozen; reset asserted mid-lw wait -> pc_out=RESET_PC immediately.
REQ-044 Opcode 0x3F with ILLEGAL_TRAP_EN -> trap_out pulse, epc_out=faulting PC, next fetch at TRAP_VEC; without macro -> pc advances by 4.
